// File: rtl/reg_trig_seq.sv
// rtl/reg_trig_seq.sv - multi-pulse trigger register bank with shadow/active commit and arm/fire/done sequencer
module reg_trig_seq #(
    parameter int          pNUM_CH       = 8,
    parameter int          pDELAY_WIDTH  = 24,
    parameter int          pWIDTH_WIDTH  = 24,
    parameter int          pREARM_WIDTH  = 16,
    parameter int          pBYTECNT_SIZE = 7,
    parameter logic [1:0]  pSELECT       = 2'b11
) (
    input  logic                              cwusb_clk,
    input  logic                              reset_n,
    input  logic [7:0]                        reg_address,
    input  logic [pBYTECNT_SIZE-1:0]          reg_bytecnt,
    input  logic [7:0]                        write_data,
    output logic [7:0]                        read_data,
    input  logic                              reg_read,
    input  logic                              reg_write,
    input  logic                              reg_addrvalid,
    output logic                              selected,
    input  logic                              I_trigger_fire,
    input  logic                              I_trigger_done,
    output logic                              O_arm,
    output logic [pNUM_CH*pDELAY_WIDTH-1:0]   O_trigger_delay,
    output logic [pNUM_CH*pWIDTH_WIDTH-1:0]   O_trigger_width,
    output logic [4:0]                        O_num_triggers
);

    typedef enum logic [2:0] {IDLE = 3'd0, ARMED = 3'd1, RUNNING = 3'd2} state_t;

    state_t                    state;
    logic                      ctrl_rearm;
    logic [7:0]                ch_sel;
    logic [pDELAY_WIDTH-1:0]   shadow_delay [pNUM_CH];
    logic [pWIDTH_WIDTH-1:0]   shadow_width [pNUM_CH];
    logic [4:0]                shadow_num;
    logic [pREARM_WIDTH-1:0]   rearm_count;
    logic [pREARM_WIDTH-1:0]   rearm_left;
    logic                      rearm_active;
    logic                      commit_pending;
    logic [31:0]               event_count;

    logic [4:0]  reg_idx;
    logic        byte0, wr, wr_ctrl, disarm, arm_req, commit_wr, ev_clear;
    logic        fire_evt, done_evt, apply_commit;
    logic [4:0]  num_clamped;
    logic [31:0] sel_delay32, sel_width32, rearm32;
    logic [7:0]  rd_mux;
    logic        unused_addr_bit;

    assign unused_addr_bit = reg_address[7];
    assign selected  = reg_addrvalid & (reg_address[6:5] == pSELECT);
    assign reg_idx   = reg_address[4:0];
    assign byte0     = (reg_bytecnt == '0);
    assign wr        = selected & reg_write;
    assign wr_ctrl   = wr & (reg_idx == 5'h00) & byte0;
    assign disarm    = wr_ctrl & ~write_data[0];
    assign arm_req   = wr_ctrl & write_data[0];
    assign commit_wr = wr_ctrl & write_data[2];
    assign ev_clear  = wr & (reg_idx == 5'h07);

    // A disarm write in the same cycle swallows fire/done so nothing is counted or committed.
    assign fire_evt     = (state == ARMED) & I_trigger_fire & ~disarm;
    assign done_evt     = (state == RUNNING) & I_trigger_done & ~disarm;
    assign apply_commit = (commit_wr | commit_pending) & ((state == IDLE) | done_evt);

    function automatic logic [7:0] get_byte(input logic [31:0] v, input logic [pBYTECNT_SIZE-1:0] idx);
        logic [7:0] r;
        r = 8'h00;
        for (int i = 0; i < 4; i++)
            if (idx == pBYTECNT_SIZE'(i)) r = v[i*8 +: 8];
        return r;
    endfunction

    always_comb begin
        num_clamped = write_data[4:0];
        if (write_data == 8'd0)
            num_clamped = 5'd1;
        else if (write_data > 8'(pNUM_CH))
            num_clamped = 5'(pNUM_CH);

        sel_delay32 = '0;
        sel_width32 = '0;
        for (int k = 0; k < pNUM_CH; k++) begin
            if (ch_sel == 8'(k)) begin
                sel_delay32[pDELAY_WIDTH-1:0] = shadow_delay[k];
                sel_width32[pWIDTH_WIDTH-1:0] = shadow_width[k];
            end
        end
        rearm32 = '0;
        rearm32[pREARM_WIDTH-1:0] = rearm_count;

        rd_mux = 8'h00;
        case (reg_idx)
            5'h00: if (byte0) rd_mux = {6'b0, ctrl_rearm, state != IDLE};
            5'h01: if (byte0) rd_mux = ch_sel;
            5'h02: rd_mux = get_byte(sel_delay32, reg_bytecnt);
            5'h03: rd_mux = get_byte(sel_width32, reg_bytecnt);
            5'h04: if (byte0) rd_mux = {3'b0, shadow_num};
            5'h05: rd_mux = get_byte(rearm32, reg_bytecnt);
            5'h06: if (byte0) rd_mux = {3'b0, commit_pending, rearm_active, state};
            5'h07: rd_mux = get_byte(event_count, reg_bytecnt);
            default: rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge cwusb_clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            O_arm          <= 1'b0;
            rearm_left     <= '0;
            rearm_active   <= 1'b0;
            commit_pending <= 1'b0;
            event_count    <= '0;
        end else begin
            commit_pending <= apply_commit ? 1'b0 : (commit_pending | commit_wr);
            if (ev_clear)
                event_count <= '0;
            else if (fire_evt && event_count != 32'hFFFF_FFFF)
                event_count <= event_count + 32'd1;

            if (disarm) begin
                state <= IDLE;
                O_arm <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (arm_req) begin
                        state        <= ARMED;
                        O_arm        <= 1'b1;
                        rearm_left   <= rearm_count;
                        rearm_active <= 1'b0;
                    end
                    ARMED: if (fire_evt) begin
                        state <= RUNNING;
                        O_arm <= 1'b0;
                    end
                    RUNNING: if (done_evt) begin
                        if (ctrl_rearm && rearm_left != '0) begin
                            state        <= ARMED;
                            O_arm        <= 1'b1;
                            rearm_left   <= rearm_left - 1'b1;
                            rearm_active <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        O_arm <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge cwusb_clk or negedge reset_n) begin
        if (!reset_n) begin
            read_data       <= 8'h00;
            ctrl_rearm      <= 1'b0;
            ch_sel          <= 8'h00;
            shadow_num      <= 5'd1;
            rearm_count     <= '0;
            O_trigger_delay <= '0;
            O_trigger_width <= '0;
            O_num_triggers  <= 5'd1;
            for (int k = 0; k < pNUM_CH; k++) begin
                shadow_delay[k] <= '0;
                shadow_width[k] <= '0;
            end
        end else begin
            read_data <= (selected & reg_read) ? rd_mux : 8'h00;
            if (wr) begin
                case (reg_idx)
                    5'h00: if (byte0) ctrl_rearm <= write_data[1];
                    5'h01: if (byte0) ch_sel <= write_data;
                    5'h02: for (int k = 0; k < pNUM_CH; k++)
                        if (ch_sel == 8'(k))
                            for (int b = 0; b < pDELAY_WIDTH; b++)
                                if (reg_bytecnt == pBYTECNT_SIZE'(b / 8))
                                    shadow_delay[k][b] <= write_data[b[2:0]];
                    5'h03: for (int k = 0; k < pNUM_CH; k++)
                        if (ch_sel == 8'(k))
                            for (int b = 0; b < pWIDTH_WIDTH; b++)
                                if (reg_bytecnt == pBYTECNT_SIZE'(b / 8))
                                    shadow_width[k][b] <= write_data[b[2:0]];
                    5'h04: if (byte0) shadow_num <= num_clamped;
                    5'h05: for (int b = 0; b < pREARM_WIDTH; b++)
                        if (reg_bytecnt == pBYTECNT_SIZE'(b / 8))
                            rearm_count[b] <= write_data[b[2:0]];
                    default: ;
                endcase
            end
            // Commit samples the shadow bank as it stood before this edge's writes.
            if (apply_commit) begin
                O_num_triggers <= shadow_num;
                for (int k = 0; k < pNUM_CH; k++) begin
                    O_trigger_delay[k*pDELAY_WIDTH +: pDELAY_WIDTH] <= shadow_delay[k];
                    O_trigger_width[k*pWIDTH_WIDTH +: pWIDTH_WIDTH] <= shadow_width[k];
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_trig_seq.sv
// tb/tb_reg_trig_seq.sv - scoreboard bench for reg_trig_seq
module tb_reg_trig_seq;

    localparam int NCH = 8;
    localparam int DW  = 24;
    localparam int WW  = 24;

    logic              cwusb_clk = 1'b0;
    logic              reset_n;
    logic [7:0]        reg_address;
    logic [6:0]        reg_bytecnt;
    logic [7:0]        write_data;
    logic [7:0]        read_data;
    logic              reg_read, reg_write, reg_addrvalid;
    logic              selected;
    logic              I_trigger_fire, I_trigger_done;
    logic              O_arm;
    logic [NCH*DW-1:0] O_trigger_delay;
    logic [NCH*WW-1:0] O_trigger_width;
    logic [4:0]        O_num_triggers;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];
    string      name_q [$];
    logic       rd_d;

    always #5 cwusb_clk = ~cwusb_clk;

    reg_trig_seq dut (
        .cwusb_clk       (cwusb_clk),
        .reset_n         (reset_n),
        .reg_address     (reg_address),
        .reg_bytecnt     (reg_bytecnt),
        .write_data      (write_data),
        .read_data       (read_data),
        .reg_read        (reg_read),
        .reg_write       (reg_write),
        .reg_addrvalid   (reg_addrvalid),
        .selected        (selected),
        .I_trigger_fire  (I_trigger_fire),
        .I_trigger_done  (I_trigger_done),
        .O_arm           (O_arm),
        .O_trigger_delay (O_trigger_delay),
        .O_trigger_width (O_trigger_width),
        .O_num_triggers  (O_num_triggers)
    );

    always @(posedge cwusb_clk or negedge reset_n) begin
        if (!reset_n) rd_d <= 1'b0;
        else          rd_d <= reg_read & reg_addrvalid & (reg_address[6:5] == 2'b11);
    end

    // Monitor: each qualified read cycle pops one expectation; all other cycles must read 0.
    always @(negedge cwusb_clk) begin
        logic [7:0] e;
        string      n;
        checks++;
        if (rd_d) begin
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty: read_data=%h with nothing expected", read_data);
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (read_data !== e) begin
                    errors++;
                    $display("FAIL %s: read_data=%h expected=%h", n, read_data, e);
                end
            end
        end else if (read_data !== 8'h00) begin
            errors++;
            $display("FAIL idle_read_data: read_data=%h expected=00", read_data);
        end
    end

    task automatic tick();
        @(posedge cwusb_clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] e);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", n, act, e);
        end
    endtask

    task automatic bus_wr(input logic [4:0] a, input logic [6:0] bc, input logic [7:0] d);
        reg_address   = {3'b011, a};
        reg_bytecnt   = bc;
        write_data    = d;
        reg_addrvalid = 1'b1;
        reg_write     = 1'b1;
        tick();
        reg_write     = 1'b0;
        reg_addrvalid = 1'b0;
    endtask

    task automatic bus_rd(input logic [4:0] a, input logic [6:0] bc, input logic [7:0] e, input string n);
        reg_address   = {3'b011, a};
        reg_bytecnt   = bc;
        reg_addrvalid = 1'b1;
        reg_read      = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(n);
        tick();
        reg_read      = 1'b0;
        reg_addrvalid = 1'b0;
    endtask

    task automatic pulse_fire();
        I_trigger_fire = 1'b1;
        tick();
        I_trigger_fire = 1'b0;
    endtask

    task automatic pulse_done();
        I_trigger_done = 1'b1;
        tick();
        I_trigger_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        reg_address = 8'h00; reg_bytecnt = '0; write_data = 8'h00;
        reg_read = 1'b0; reg_write = 1'b0; reg_addrvalid = 1'b0;
        I_trigger_fire = 1'b0; I_trigger_done = 1'b0;
        repeat (3) @(posedge cwusb_clk);
        #1;
        chk("reset_arm", 32'(O_arm), 32'd0);
        chk("reset_num", 32'(O_num_triggers), 32'd1);
        chk("reset_delay", 32'(|O_trigger_delay), 32'd0);
        chk("reset_width", 32'(|O_trigger_width), 32'd0);
        reset_n = 1'b1;
        tick();

        reg_addrvalid = 1'b1; reg_address = 8'h40; #1;
        chk("selected_other_block", 32'(selected), 32'd0);
        reg_address = 8'h60; #1;
        chk("selected_this_block", 32'(selected), 32'd1);
        reg_addrvalid = 1'b0; #1;
        chk("selected_no_addrvalid", 32'(selected), 32'd0);

        bus_rd(5'h04, 0, 8'h01, "num_reset");
        bus_rd(5'h06, 0, 8'h00, "status_reset");
        bus_rd(5'h00, 0, 8'h00, "ctrl_reset");
        for (int ch = 0; ch < NCH; ch++) begin
            bus_wr(5'h01, 0, 8'(ch));
            for (int b = 0; b < 4; b++) bus_rd(5'h02, 7'(b), 8'h00, "delay_reset");
        end

        bus_wr(5'h01, 0, 8'd3);
        bus_wr(5'h02, 0, 8'h11);
        bus_wr(5'h02, 1, 8'h22);
        bus_wr(5'h02, 2, 8'h33);
        bus_wr(5'h02, 3, 8'h44);
        bus_rd(5'h02, 0, 8'h11, "delay_b0");
        bus_rd(5'h02, 1, 8'h22, "delay_b1");
        bus_rd(5'h02, 2, 8'h33, "delay_b2");
        bus_rd(5'h02, 3, 8'h00, "delay_b3_beyond");
        chk("delay_before_commit", O_trigger_delay[72 +: 24], 32'h0);
        bus_wr(5'h00, 0, 8'h04);
        chk("commit_idle_ch3", O_trigger_delay[72 +: 24], 32'h332211);
        chk("commit_idle_ch2", O_trigger_delay[48 +: 24], 32'h0);
        bus_rd(5'h00, 0, 8'h00, "ctrl_commit_selfclear");
        bus_wr(5'h01, 0, 8'd8);
        bus_wr(5'h02, 0, 8'h55);
        bus_rd(5'h02, 0, 8'h00, "delay_chsel_oob");
        bus_wr(5'h01, 0, 8'd3);
        bus_rd(5'h02, 0, 8'h11, "delay_after_oob_write");
        bus_wr(5'h04, 0, 8'd0);
        bus_rd(5'h04, 0, 8'h01, "num_clamp_zero");
        bus_wr(5'h04, 0, 8'd20);
        bus_rd(5'h04, 0, 8'h08, "num_clamp_high");
        bus_wr(5'h04, 0, 8'd5);
        bus_rd(5'h04, 0, 8'h05, "num_five");

        bus_wr(5'h00, 0, 8'h01);
        chk("arm_rise", 32'(O_arm), 32'd1);
        bus_rd(5'h06, 0, 8'h01, "status_armed");
        bus_rd(5'h00, 0, 8'h01, "ctrl_armed");
        bus_wr(5'h03, 0, 8'hAA);
        bus_wr(5'h03, 1, 8'hBB);
        bus_wr(5'h00, 0, 8'h05);
        chk("width_held_armed", O_trigger_width[72 +: 24], 32'h0);
        chk("num_held_armed", 32'(O_num_triggers), 32'd1);
        bus_rd(5'h06, 0, 8'h11, "status_armed_pending");
        pulse_fire();
        chk("arm_fall_on_fire", 32'(O_arm), 32'd0);
        bus_rd(5'h06, 0, 8'h12, "status_running");
        chk("width_held_running", O_trigger_width[72 +: 24], 32'h0);
        pulse_done();
        chk("width_on_done", O_trigger_width[72 +: 24], 32'h00BBAA);
        chk("num_on_done", 32'(O_num_triggers), 32'd5);
        chk("delay_kept_on_done", O_trigger_delay[72 +: 24], 32'h332211);
        bus_rd(5'h06, 0, 8'h00, "status_idle_after_done");
        bus_rd(5'h00, 0, 8'h00, "ctrl_arm_cleared");
        bus_rd(5'h07, 0, 8'h01, "evcnt_one");

        bus_wr(5'h07, 0, 8'hFF);
        bus_rd(5'h07, 0, 8'h00, "evcnt_cleared");
        bus_wr(5'h05, 0, 8'h02);
        bus_wr(5'h05, 1, 8'h00);
        bus_rd(5'h05, 0, 8'h02, "rearm_b0");
        bus_rd(5'h05, 2, 8'h00, "rearm_b2_beyond");
        bus_wr(5'h00, 0, 8'h03);
        chk("autorearm_arm", 32'(O_arm), 32'd1);
        for (int i = 0; i < 3; i++) begin
            pulse_fire();
            chk("autorearm_fire_arm_low", 32'(O_arm), 32'd0);
            pulse_done();
            chk("autorearm_after_done", 32'(O_arm), (i < 2) ? 32'd1 : 32'd0);
        end
        bus_rd(5'h00, 0, 8'h02, "ctrl_after_autorearm");
        bus_rd(5'h07, 0, 8'h03, "evcnt_three_b0");
        bus_rd(5'h07, 1, 8'h00, "evcnt_three_b1");
        bus_rd(5'h07, 3, 8'h00, "evcnt_three_b3");

        bus_wr(5'h00, 0, 8'h01);
        chk("arm_for_abort", 32'(O_arm), 32'd1);
        I_trigger_fire = 1'b1;
        bus_wr(5'h00, 0, 8'h00);
        I_trigger_fire = 1'b0;
        chk("abort_arm_low", 32'(O_arm), 32'd0);
        bus_rd(5'h06, 0, 8'h00, "status_after_abort");
        bus_rd(5'h07, 0, 8'h03, "evcnt_abort_unchanged");
        pulse_fire();
        bus_rd(5'h07, 0, 8'h03, "evcnt_fire_idle");
        bus_rd(5'h06, 0, 8'h00, "status_fire_idle");
        bus_wr(5'h00, 0, 8'h01);
        I_trigger_fire = 1'b1;
        bus_wr(5'h07, 0, 8'h00);
        I_trigger_fire = 1'b0;
        bus_rd(5'h06, 0, 8'h02, "status_fire_with_clear");
        bus_rd(5'h07, 0, 8'h00, "evcnt_fire_with_clear");
        pulse_done();
        bus_rd(5'h06, 0, 8'h00, "status_idle_again");

        bus_wr(5'h00, 0, 8'h01);
        bus_wr(5'h02, 0, 8'h77);
        bus_wr(5'h00, 0, 8'h05);
        pulse_fire();
        bus_rd(5'h06, 0, 8'h12, "status_running_pending");
        #6;
        reset_n = 1'b0;
        #1;
        chk("async_reset_delay", O_trigger_delay[72 +: 24], 32'h0);
        chk("async_reset_width", O_trigger_width[72 +: 24], 32'h0);
        chk("async_reset_num", 32'(O_num_triggers), 32'd1);
        chk("async_reset_arm", 32'(O_arm), 32'd0);
        chk("async_reset_read_data", 32'(read_data), 32'd0);
        repeat (2) @(posedge cwusb_clk);
        #1;
        reset_n = 1'b1;
        tick();
        bus_rd(5'h06, 0, 8'h00, "status_after_reset");
        bus_rd(5'h04, 0, 8'h01, "num_after_reset");
        bus_rd(5'h02, 0, 8'h00, "delay_after_reset");
        tick();
        tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_trig_seq.md
# reg_trig_seq

Parametrised successor register block for the multi-pulse trigger generator, on `cwusb_clk` behind `usb_reg_main`. It holds per-channel delay/width values in a shadow bank with atomic commit to an active bank. It runs an arm/fire/done sequencer with optional auto-rearm and a trigger event counter. All logic is in one clock domain; any CDC to the front-end clock sits outside this block.

## Interface
- `pNUM_CH`, 8: trigger pulse channels (1..16).
- `pDELAY_WIDTH`, 24: bits per channel delay (8..32).
- `pWIDTH_WIDTH`, 24: bits per channel width (8..32).
- `pREARM_WIDTH`, 16: auto-rearm counter bits.
- `pBYTECNT_SIZE`, 7: width of `reg_bytecnt`.
- `pSELECT`, 2'b11: value of `reg_address[6:5]` that selects this block.
- `cwusb_clk` in 1: sole clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `reg_address` in 8: [6:5] block select, [4:0] register.
- `reg_bytecnt` in pBYTECNT_SIZE: byte index within a multi-byte register.
- `write_data` in 8: write byte.
- `read_data` out 8: registered read byte.
- `reg_read`, `reg_write`, `reg_addrvalid` in 1 each: bus strobes.
- `selected` out 1: `reg_addrvalid & (reg_address[6:5]==pSELECT)`, combinational.
- `I_trigger_fire` in 1: one-cycle pulse when the generator starts a sequence.
- `I_trigger_done` in 1: one-cycle pulse when the last pulse ends.
- `O_arm` out 1: high only in ARMED.
- `O_trigger_delay` out pNUM_CH*pDELAY_WIDTH: active bank, channel k at [k*pDELAY_WIDTH +: pDELAY_WIDTH].
- `O_trigger_width` out pNUM_CH*pWIDTH_WIDTH: active bank, same layout.
- `O_num_triggers` out 5: active channel count.

## Operation
- Registers at `reg_address[4:0]`:
  - 0x00 CTRL: bit0 arm, bit1 auto-rearm enable, bit2 commit (write-1, self-clearing).
  - 0x01 CH_SEL.
  - 0x02 DELAY: shadow, selected channel.
  - 0x03 WIDTH: shadow, selected channel.
  - 0x04 NUM_TRIGGERS: shadow.
  - 0x05 REARM_COUNT.
  - 0x06 STATUS, read-only: {3'b0, commit_pending, rearm_active, state[2:0]}, state IDLE=0, ARMED=1, RUNNING=2.
  - 0x07 EVENT_COUNT, read-only: 32-bit.
- Multi-byte registers are little-endian by `reg_bytecnt`.
  - Writes to bytes beyond the register width are ignored; reads of those bytes return 0.
  - Upper bits of a partially used byte are dropped on write and read as 0.
- CH_SEL >= pNUM_CH: DELAY/WIDTH writes are ignored and reads return 0.
- NUM_TRIGGERS write: 0 clamps to 1; values above pNUM_CH clamp to pNUM_CH.
- Commit copies shadow DELAY/WIDTH/NUM into the active bank in one cycle.
  - In IDLE: applied on the cycle after the write.
  - In ARMED or RUNNING: sets commit_pending; applied on the `I_trigger_done` cycle.
- FSM:
  - IDLE --CTRL write arm=1--> ARMED. This loads rearm_left=REARM_COUNT and clears rearm_active.
  - ARMED --`I_trigger_fire`--> RUNNING. EVENT_COUNT increments.
  - RUNNING --`I_trigger_done`--> ARMED if auto-rearm=1 and rearm_left!=0; rearm_left then decrements and rearm_active=1. Otherwise --> IDLE, and CTRL.arm reads back 0.
  - CTRL write arm=0 in any state --> IDLE (abort). commit_pending is kept; a pending commit is applied on the next IDLE cycle.
- EVENT_COUNT saturates at 0xFFFFFFFF. Writing any byte of 0x07 clears it.
- `I_trigger_fire` outside ARMED and `I_trigger_done` outside RUNNING are ignored.

## Timing
- Reset, asynchronous while `reset_n`=0:
  - `O_arm`=0, state IDLE, `read_data`=0.
  - Shadow and active delay/width banks 0; active and shadow NUM=1.
  - CTRL=0, CH_SEL=0, REARM_COUNT=0, EVENT_COUNT=0, commit_pending=0.
  - Reset mid-sequence returns to IDLE immediately. Release is synchronous to the next `cwusb_clk` edge.
- Read: `read_data` is valid the cycle after `selected & reg_read`, and 0 on any cycle without that qualifier.
- Write: takes effect on the edge where `selected & reg_write`.
- `O_arm` rises one cycle after the arming write and falls in the cycle after `I_trigger_fire`.
- Simultaneous events, same cycle:
  - Disarm write beats fire and done: the event is not counted and any pending commit waits for IDLE.
  - Commit write with done: the commit is applied at that edge.
  - Fire with an EVENT_COUNT clear: the count becomes 0.
- Active bank outputs change only on a commit edge and never glitch mid-sequence.

## Test plan
- Reset, then read 0x04 and 0x06 -> 0x01 and 0x00.
- Reset, then read 0x02 bytes 0..3 for every channel -> all 0.
- CH_SEL=3; write DELAY bytes 0x11,0x22,0x33; commit in IDLE -> `O_trigger_delay[72+:24]`=0x332211 one cycle later. Write NUM=0 -> reads back 1. Write NUM=20 -> reads back 8.
- Arm, then shadow-write WIDTH and commit -> active bank unchanged while ARMED. Pulse fire, then done -> active bank updates on the done edge; STATUS goes 1 -> 2 -> 0.
- REARM_COUNT=2, auto-rearm=1, arm, then 3 fire/done pairs -> `O_arm` reasserts twice, the final done returns to IDLE, EVENT_COUNT=3.
- Fire and disarm write in the same cycle -> IDLE, EVENT_COUNT unchanged. Fire while IDLE -> ignored.
- Assert `reset_n` low mid-RUNNING with commit pending -> outputs return to reset values asynchronously; commit_pending=0 after release.
